// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: operand width, op encodings
// and the iterative FSM state encoding.
package mips_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Request/response bundle between a requester and the multiply/divide unit.
interface mult_div_if
  import mips_pkg::*;
#(
  parameter int W = WIDTH
);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (output a, b, op, start, input busy, done, hi, lo);
  modport slave  (input a, b, op, start, output busy, done, hi, lo);
endinterface

// File: rtl/md_sign_fix.sv
// Combinational sign restoration of a magnitude result: negates the 64-bit
// product, or quotient/remainder independently; forces lo to all ones on /0.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc_i,
  input  logic           is_mult_i,
  input  logic           neg_lo_i,
  input  logic           neg_hi_i,
  input  logic           div0_i,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o
);

  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  always_comb begin
    prod = '0;
    quot = '0;
    rem  = '0;
    hi_o = '0;
    lo_o = '0;
    if (is_mult_i) begin
      prod = neg_lo_i ? ('0 - acc_i) : acc_i;
      hi_o = prod[2*W-1:W];
      lo_o = prod[W-1:0];
    end else begin
      quot = neg_lo_i ? ('0 - acc_i[W-1:0]) : acc_i[W-1:0];
      rem  = neg_hi_i ? ('0 - acc_i[2*W-1:W]) : acc_i[2*W-1:W];
      // Remainder already equals a on /0; only the quotient needs forcing.
      lo_o = div0_i ? '1 : quot;
      hi_o = rem;
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative 32-cycle multiply/divide unit sharing one accumulator and one
// adder/subtractor; signed ops run on magnitudes and are fixed up in FIX.
module mult_div
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  mult_div_if.slave md
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  md_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W2-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic           is_mult_q, is_mult_d;
  logic           neg_lo_q, neg_lo_d;
  logic           neg_hi_q, neg_hi_d;
  logic           div0_q, div0_d;
  logic           done_q, done_d;

  logic             a_neg, b_neg, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sub;
  logic [WIDTH:0]   add_x, add_y;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  always_comb begin
    is_div = op_is_div(md.op);
    a_neg  = op_is_signed(md.op) & md.a[WIDTH-1];
    b_neg  = op_is_signed(md.op) & md.b[WIDTH-1];
    a_mag  = a_neg ? ('0 - md.a) : md.a;
    b_mag  = b_neg ? ('0 - md.b) : md.b;
  end

  // Multiply adds into the upper half; divide trial-subtracts the shifted
  // partial remainder, whose carry-out means "fits".
  always_comb begin
    sub     = ~is_mult_q;
    add_x   = is_mult_q ? {1'b0, acc_q[W2-1:WIDTH]} : acc_q[W2-1:WIDTH-1];
    add_y   = {1'b0, mb_q};
    add_sum = {1'b0, add_x} + {1'b0, (sub ? ~add_y : add_y)}
            + {{(WIDTH+1){1'b0}}, sub};
  end

  md_sign_fix #(.W(WIDTH)) u_sign_fix (
    .acc_i     (acc_q),
    .is_mult_i (is_mult_q),
    .neg_lo_i  (neg_lo_q),
    .neg_hi_i  (neg_hi_q),
    .div0_i    (div0_q),
    .hi_o      (fix_hi),
    .lo_o      (fix_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mb_d      = mb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_mult_d = is_mult_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          state_d   = MD_RUN;
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          mb_d      = b_mag;
          is_mult_d = ~is_div;
          neg_lo_d  = a_neg ^ b_neg;
          neg_hi_d  = is_div ? a_neg : (a_neg ^ b_neg);
          div0_d    = is_div & (md.b == '0);
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_mult_q) begin
          acc_d = acc_q[0] ? {add_sum[WIDTH:0], acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[W2-1:1]};
        end else begin
          acc_d = add_sum[WIDTH+1] ? {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                   : {acc_q[W2-2:0], 1'b0};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mb_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_mult_q <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mb_q      <= mb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_mult_q <= is_mult_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign md.busy = (state_q != MD_IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a  input  32  dividend or multiplicand, sampled only when a start is accepted.
REQ-005 SHALL have port b  input  32  divisor or multiplier, sampled only when a start is accepted.
REQ-006 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 SHALL have port start  input  1  request strobe.
REQ-008 SHALL have port busy  output  1  an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse: hi/lo were updated at this edge.
REQ-010 SHALL have port hi  output  32  multiply: upper product; divide: remainder.
REQ-011 SHALL have port lo  output  32  multiply: lower product; divide: quotient.

Function
REQ-012 SHALL accept a start only when start=1 and busy=0 at a rising edge; a, b and op are latched at that edge.
REQ-013 SHALL ignore start while busy=1: no latching, and the running operation is unaffected.
REQ-014 SHALL use the states IDLE -> RUN (32 cycles, one bit per cycle, shift-add or restoring subtract) -> FIX (1 cycle, sign correction) -> IDLE.
REQ-015 SHALL assert busy from the edge of acceptance until the edge that leaves FIX.
REQ-016 SHALL pulse done for exactly one cycle at the edge leaving FIX, which is 33 edges after acceptance, for every op.
REQ-017 SHALL write hi/lo only at the done edge; hi/lo SHALL hold their values at all other times.
REQ-018 SHALL accept a new start in the cycle done=1, since busy=0 in that cycle.
REQ-019 SHALL compute signed ops (MULT, DIV) on operand magnitudes and apply the sign correction in FIX.
REQ-020 SHALL return a 64-bit two's-complement product for MULT, split as {hi,lo}.
REQ-021 SHALL make the DIV quotient negative iff the operand signs differ; the remainder SHALL take the sign of the dividend (truncating division).
REQ-022 SHALL produce hi=a, lo=0xFFFFFFFF on divide by zero (DIVU or DIV), with normal latency and no error flag.
REQ-023 SHALL produce lo=0x80000000, hi=0 for DIV 0x80000000 / 0xFFFFFFFF (wrap, no trap).
REQ-024 SHALL compute all arithmetic modulo 2^64 (mult) or 2^32 (div); no exceptions are raised.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear all internal registers, independent of clk.
REQ-026 SHALL abort any in-flight operation on reset without producing a done pulse.
REQ-027 SHALL accept start at the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL take the op encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV), WIDTH and the state encoding from the shared package mips_pkg.
REQ-029 SHALL use one shared 64-bit accumulator/shift register and one 33-bit adder/subtractor for both multiply and divide.
REQ-030 SHALL place the sign correction (conditional two's-complement negate of quotient/remainder/product) in the sub-module md_sign_fix, which is purely combinational.

Verification
REQ-031 SHALL verify MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL verify MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 SHALL verify DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-034 SHALL verify DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 SHALL verify start DIVU 100/7, then start MULTU 3*3 at cycle 5 -> second start ignored; done once with lo=14, hi=2; back-to-back start in the done cycle is accepted.
REQ-036 SHALL verify rst_n pulsed low at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately, and no done pulse follows.
